// File: rtl/memory_i2c_wb_arb_if.sv
// Wishbone B3 port bundle shared by both arbiter masters and the RAM slave side.
`timescale 1ns/1ps
interface memory_i2c_wb_arb_if #(
  parameter int AW = 32,
  parameter int DW = 8,
  parameter int SW = 4
);
  logic [AW-1:0] adr;
  logic [DW-1:0] wdat;
  logic [DW-1:0] rdat;
  logic [SW-1:0] sel;
  logic          we;
  logic          cyc;
  logic          stb;
  logic [2:0]    cti;
  logic          ack;
  logic          err;

  modport master (output adr, wdat, sel, we, cyc, stb, cti, input rdat, ack, err);
  modport slave  (input adr, wdat, sel, we, cyc, stb, cti, output rdat, ack, err);
endinterface

// File: rtl/memory_i2c_wb_arb.sv
// Two-master round-robin Wishbone arbiter for the memory_i2c RAM; grant held for a whole cyc.
// Optional slave watchdog with sticky timeout_o enabled by MEMORY_I2C_WB_ARB_TIMEOUT_EN.
`timescale 1ns/1ps
module memory_i2c_wb_arb #(
  parameter int AW = 32,
  parameter int DW = 8,
  parameter int SW = 4
`ifdef MEMORY_I2C_WB_ARB_TIMEOUT_EN
  , parameter int TIMEOUT = 255
`endif
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  memory_i2c_wb_arb_if.slave   m0,
  memory_i2c_wb_arb_if.slave   m1,
  memory_i2c_wb_arb_if.master  s,
`ifdef MEMORY_I2C_WB_ARB_TIMEOUT_EN
  output logic                 timeout_o,
`endif
  output logic [1:0]           gnt_o
);

  typedef enum logic [1:0] {IDLE, GNT0, GNT1} state_t;

  state_t        state, state_nxt;
  logic          last_gnt;
  logic [AW-1:0] adr_mux;
  logic [DW-1:0] wdat_mux;
  logic [SW-1:0] sel_mux;
  logic          we_mux, cyc_mux, stb_mux;
  logic [2:0]    cti_mux;
  logic          fire;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state    <= IDLE;
      last_gnt <= 1'b1;
    end else begin
      state <= state_nxt;
      if (state == IDLE && state_nxt == GNT0) last_gnt <= 1'b0;
      if (state == IDLE && state_nxt == GNT1) last_gnt <= 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (m0.cyc && m1.cyc) state_nxt = last_gnt ? GNT0 : GNT1;
        else if (m0.cyc)      state_nxt = GNT0;
        else if (m1.cyc)      state_nxt = GNT1;
      end
      GNT0:    if (!m0.cyc || fire) state_nxt = IDLE;
      GNT1:    if (!m1.cyc || fire) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Request mux; stb is qualified by cyc so a stray strobe never reaches the slave.
  always_comb begin
    adr_mux  = '0;
    wdat_mux = '0;
    sel_mux  = '0;
    we_mux   = 1'b0;
    cyc_mux  = 1'b0;
    stb_mux  = 1'b0;
    cti_mux  = 3'b000;
    unique case (state)
      GNT0: begin
        adr_mux  = m0.adr;
        wdat_mux = m0.wdat;
        sel_mux  = m0.sel;
        we_mux   = m0.we;
        cyc_mux  = m0.cyc;
        stb_mux  = m0.stb & m0.cyc;
        cti_mux  = m0.cti;
      end
      GNT1: begin
        adr_mux  = m1.adr;
        wdat_mux = m1.wdat;
        sel_mux  = m1.sel;
        we_mux   = m1.we;
        cyc_mux  = m1.cyc;
        stb_mux  = m1.stb & m1.cyc;
        cti_mux  = m1.cti;
      end
      default: ;
    endcase
  end

`ifdef MEMORY_I2C_WB_ARB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] cnt;

  // Fires on the TIMEOUT-th stalled strobe cycle, so the err pulse lands inside that cycle.
  assign fire = (state != IDLE) && stb_mux && !s.ack && !s.err && (cnt == TW'(TIMEOUT - 1));

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      cnt       <= '0;
      timeout_o <= 1'b0;
    end else begin
      if (state == IDLE || s.ack || s.err) cnt <= '0;
      else if (stb_mux)                    cnt <= cnt + 1'b1;
      if (fire)                  timeout_o <= 1'b1;
      else if (m0.ack || m1.ack) timeout_o <= 1'b0;
    end
  end
`else
  assign fire = 1'b0;
`endif

  assign s.adr  = adr_mux;
  assign s.wdat = wdat_mux;
  assign s.sel  = sel_mux;
  assign s.we   = we_mux;
  assign s.cti  = cti_mux;
  assign s.cyc  = cyc_mux & ~fire;
  assign s.stb  = stb_mux & ~fire;

  // Responses gated by the master's own cyc so an abandoned transfer's late ack goes nowhere.
  assign m0.ack  = (state == GNT0) & m0.cyc & s.ack;
  assign m1.ack  = (state == GNT1) & m1.cyc & s.ack;
  assign m0.err  = (state == GNT0) & ((m0.cyc & s.err) | fire);
  assign m1.err  = (state == GNT1) & ((m1.cyc & s.err) | fire);
  assign m0.rdat = s.rdat;
  assign m1.rdat = s.rdat;

  assign gnt_o = {state == GNT1, state == GNT0};

endmodule

// File: tb/tb_memory_i2c_wb_arb.sv
// Directed bench for memory_i2c_wb_arb: grant/ack routing, round-robin, bursts, abandon, reset, watchdog.
`timescale 1ns/1ps
module tb_memory_i2c_wb_arb;
  logic       clk_i = 1'b0;
  logic       rst_i = 1'b0;
  logic [1:0] gnt;
  logic       slv_en = 1'b0;
  logic       man_ack = 1'b0;
  logic       man_err = 1'b0;
  logic [7:0] mem [0:255];
  int         vec = 0;
  int         miss = 0;
`ifdef MEMORY_I2C_WB_ARB_TIMEOUT_EN
  logic       timeout;
`endif

  memory_i2c_wb_arb_if #(.AW(32), .DW(8), .SW(4)) m0_bus ();
  memory_i2c_wb_arb_if #(.AW(32), .DW(8), .SW(4)) m1_bus ();
  memory_i2c_wb_arb_if #(.AW(32), .DW(8), .SW(4)) s_bus ();

`ifdef MEMORY_I2C_WB_ARB_TIMEOUT_EN
  memory_i2c_wb_arb #(.AW(32), .DW(8), .SW(4), .TIMEOUT(8)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .m0(m0_bus), .m1(m1_bus), .s(s_bus),
    .timeout_o(timeout), .gnt_o(gnt));
`else
  memory_i2c_wb_arb #(.AW(32), .DW(8), .SW(4)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .m0(m0_bus), .m1(m1_bus), .s(s_bus), .gnt_o(gnt));
`endif

  always #5 clk_i = ~clk_i;

  // Zero-wait RAM slave model, plus manual ack/err for stall scenarios.
  assign s_bus.ack  = (slv_en & s_bus.cyc & s_bus.stb) | man_ack;
  assign s_bus.err  = man_err;
  assign s_bus.rdat = mem[s_bus.adr[7:0]];
  always @(posedge clk_i)
    if (s_bus.cyc && s_bus.stb && s_bus.ack && s_bus.we) mem[s_bus.adr[7:0]] <= s_bus.wdat;

  task automatic tick();
    @(posedge clk_i);
    #2;
  endtask

  task automatic idle_all();
    m0_bus.adr = '0; m0_bus.wdat = '0; m0_bus.sel = '0; m0_bus.we = 0;
    m0_bus.cyc = 0;  m0_bus.stb = 0;   m0_bus.cti = '0;
    m1_bus.adr = '0; m1_bus.wdat = '0; m1_bus.sel = '0; m1_bus.we = 0;
    m1_bus.cyc = 0;  m1_bus.stb = 0;   m1_bus.cti = '0;
  endtask

  task automatic test_reset();
    rst_i = 1'b0;
    idle_all();
    tick(); tick(); #1;
    vec++; if (gnt !== 2'b00)         begin miss++; $display("FAIL rst_gnt got %b want 00", gnt); end
    vec++; if (s_bus.cyc !== 1'b0)    begin miss++; $display("FAIL rst_cyc got %b want 0", s_bus.cyc); end
    vec++; if (s_bus.stb !== 1'b0)    begin miss++; $display("FAIL rst_stb got %b want 0", s_bus.stb); end
    vec++; if (s_bus.adr !== 32'h0)   begin miss++; $display("FAIL rst_adr got %h want 0", s_bus.adr); end
    vec++; if (s_bus.cti !== 3'b000)  begin miss++; $display("FAIL rst_cti got %b want 000", s_bus.cti); end
    vec++; if (m0_bus.ack !== 1'b0)   begin miss++; $display("FAIL rst_m0ack got %b want 0", m0_bus.ack); end
    vec++; if (m1_bus.err !== 1'b0)   begin miss++; $display("FAIL rst_m1err got %b want 0", m1_bus.err); end
`ifdef MEMORY_I2C_WB_ARB_TIMEOUT_EN
    vec++; if (timeout !== 1'b0)      begin miss++; $display("FAIL rst_timeout got %b want 0", timeout); end
`endif
    rst_i = 1'b1;
    tick();
  endtask

  task automatic test_single_write();
    slv_en = 1'b1;
    m0_bus.adr = 32'h10; m0_bus.wdat = 8'hA5; m0_bus.sel = 4'h1; m0_bus.we = 1;
    m0_bus.cyc = 1; m0_bus.stb = 1; m0_bus.cti = 3'b000;
    #1;
    vec++; if (s_bus.cyc !== 1'b0)    begin miss++; $display("FAIL wr_latency got %b want 0", s_bus.cyc); end
    tick(); #1;
    vec++; if (gnt !== 2'b01)         begin miss++; $display("FAIL wr_gnt got %b want 01", gnt); end
    vec++; if (s_bus.cyc !== 1'b1)    begin miss++; $display("FAIL wr_cyc got %b want 1", s_bus.cyc); end
    vec++; if (s_bus.adr !== 32'h10)  begin miss++; $display("FAIL wr_adr got %h want 10", s_bus.adr); end
    vec++; if (s_bus.wdat !== 8'hA5)  begin miss++; $display("FAIL wr_dat got %h want a5", s_bus.wdat); end
    vec++; if (s_bus.we !== 1'b1)     begin miss++; $display("FAIL wr_we got %b want 1", s_bus.we); end
    vec++; if (m0_bus.ack !== 1'b1)   begin miss++; $display("FAIL wr_m0ack got %b want 1", m0_bus.ack); end
    vec++; if (m1_bus.ack !== 1'b0)   begin miss++; $display("FAIL wr_m1ack got %b want 0", m1_bus.ack); end
    tick();
    m0_bus.cyc = 0; m0_bus.stb = 0; m0_bus.we = 0;
    #1;
    vec++; if (s_bus.cyc !== 1'b0)    begin miss++; $display("FAIL wr_drop_cyc got %b want 0", s_bus.cyc); end
    tick();
    vec++; if (gnt !== 2'b00)         begin miss++; $display("FAIL wr_idle got %b want 00", gnt); end
    m1_bus.adr = 32'h10; m1_bus.we = 0; m1_bus.cyc = 1; m1_bus.stb = 1;
    tick(); #1;
    vec++; if (gnt !== 2'b10)         begin miss++; $display("FAIL rd_gnt got %b want 10", gnt); end
    vec++; if (m1_bus.ack !== 1'b1)   begin miss++; $display("FAIL rd_m1ack got %b want 1", m1_bus.ack); end
    vec++; if (m1_bus.rdat !== 8'hA5) begin miss++; $display("FAIL rd_data got %h want a5", m1_bus.rdat); end
    vec++; if (m0_bus.ack !== 1'b0)   begin miss++; $display("FAIL rd_m0ack got %b want 0", m0_bus.ack); end
    tick();
    m1_bus.cyc = 0; m1_bus.stb = 0;
    tick();
  endtask

  task automatic test_round_robin();
    logic [1:0]  exp_gnt;
    logic [31:0] exp_adr;
    rst_i = 1'b0; #1; rst_i = 1'b1;
    slv_en = 1'b0;
    m0_bus.adr = 32'h30; m0_bus.we = 0; m0_bus.cyc = 1; m0_bus.stb = 1;
    m1_bus.adr = 32'h31; m1_bus.we = 0; m1_bus.cyc = 1; m1_bus.stb = 1;
    for (int i = 0; i < 4; i++) begin
      exp_gnt = (i % 2 == 0) ? 2'b01 : 2'b10;
      exp_adr = (i % 2 == 0) ? 32'h30 : 32'h31;
      tick(); #1;
      vec++; if (gnt !== exp_gnt)     begin miss++; $display("FAIL rr_gnt%0d got %b want %b", i, gnt, exp_gnt); end
      vec++; if (s_bus.adr !== exp_adr) begin miss++; $display("FAIL rr_adr%0d got %h want %h", i, s_bus.adr, exp_adr); end
      if (i % 2 == 0) m0_bus.cyc = 0; else m1_bus.cyc = 0;
      tick();
      vec++; if (gnt !== 2'b00)       begin miss++; $display("FAIL rr_idle%0d got %b want 00", i, gnt); end
      if (i % 2 == 0) m0_bus.cyc = 1; else m1_bus.cyc = 1;
    end
    idle_all();
    tick(); tick();
  endtask

  task automatic test_burst();
    slv_en = 1'b1;
    m1_bus.adr = 32'h20; m1_bus.we = 0; m1_bus.cti = 3'b010; m1_bus.cyc = 1; m1_bus.stb = 1;
    tick();
    m0_bus.adr = 32'h50; m0_bus.we = 0; m0_bus.cyc = 1; m0_bus.stb = 1;
    for (int b = 0; b < 4; b++) begin
      #1;
      vec++; if (gnt !== 2'b10)       begin miss++; $display("FAIL burst_gnt%0d got %b want 10", b, gnt); end
      vec++; if (m1_bus.ack !== 1'b1) begin miss++; $display("FAIL burst_m1ack%0d got %b want 1", b, m1_bus.ack); end
      vec++; if (m0_bus.ack !== 1'b0) begin miss++; $display("FAIL burst_m0ack%0d got %b want 0", b, m0_bus.ack); end
      if (b < 3) begin
        tick();
        m1_bus.adr = 32'h21 + 32'(b);
        m1_bus.cti = (b == 2) ? 3'b111 : 3'b010;
      end
    end
    tick();
    m1_bus.cyc = 0; m1_bus.stb = 0; m1_bus.cti = 3'b000;
    #1;
    vec++; if (s_bus.cyc !== 1'b0)    begin miss++; $display("FAIL burst_end_cyc got %b want 0", s_bus.cyc); end
    vec++; if (m0_bus.ack !== 1'b0)   begin miss++; $display("FAIL burst_blocked got %b want 0", m0_bus.ack); end
    tick();
    vec++; if (gnt !== 2'b00)         begin miss++; $display("FAIL burst_idle got %b want 00", gnt); end
    tick(); #1;
    vec++; if (gnt !== 2'b01)         begin miss++; $display("FAIL burst_m0_next got %b want 01", gnt); end
    idle_all();
    tick(); tick();
  endtask

  task automatic test_abandon();
    slv_en = 1'b0;
    m0_bus.adr = 32'h60; m0_bus.we = 0; m0_bus.cyc = 1; m0_bus.stb = 1;
    tick(); #1;
    vec++; if (gnt !== 2'b01)         begin miss++; $display("FAIL ab_gnt got %b want 01", gnt); end
    vec++; if (m0_bus.ack !== 1'b0)   begin miss++; $display("FAIL ab_stall got %b want 0", m0_bus.ack); end
    tick();
    m0_bus.cyc = 0; m0_bus.stb = 0; man_ack = 1'b1;
    #1;
    vec++; if (m0_bus.ack !== 1'b0)   begin miss++; $display("FAIL ab_m0ack got %b want 0", m0_bus.ack); end
    vec++; if (m1_bus.ack !== 1'b0)   begin miss++; $display("FAIL ab_m1ack got %b want 0", m1_bus.ack); end
    tick();
    vec++; if (gnt !== 2'b00)         begin miss++; $display("FAIL ab_idle got %b want 00", gnt); end
    vec++; if (m0_bus.ack !== 1'b0)   begin miss++; $display("FAIL ab_late_m0 got %b want 0", m0_bus.ack); end
    vec++; if (m1_bus.ack !== 1'b0)   begin miss++; $display("FAIL ab_late_m1 got %b want 0", m1_bus.ack); end
    man_ack = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid();
    slv_en = 1'b0;
    m1_bus.adr = 32'h70; m1_bus.cyc = 1; m1_bus.stb = 1;
    tick(); #1;
    vec++; if (gnt !== 2'b10)         begin miss++; $display("FAIL rm_gnt got %b want 10", gnt); end
    rst_i = 1'b0;
    #1;
    vec++; if (s_bus.cyc !== 1'b0)    begin miss++; $display("FAIL rm_cyc got %b want 0", s_bus.cyc); end
    vec++; if (gnt !== 2'b00)         begin miss++; $display("FAIL rm_gnt0 got %b want 00", gnt); end
    vec++; if (m1_bus.ack !== 1'b0)   begin miss++; $display("FAIL rm_ack got %b want 0", m1_bus.ack); end
    tick();
    rst_i = 1'b1;
    m0_bus.adr = 32'h71; m0_bus.cyc = 1; m0_bus.stb = 1;
    tick(); #1;
    vec++; if (gnt !== 2'b01)         begin miss++; $display("FAIL rm_tie got %b want 01", gnt); end
    idle_all();
    tick(); tick();
  endtask

`ifdef MEMORY_I2C_WB_ARB_TIMEOUT_EN
  task automatic test_timeout();
    slv_en = 1'b0;
    m0_bus.adr = 32'h80; m0_bus.cyc = 1; m0_bus.stb = 1;
    tick();
    for (int c = 1; c < 8; c++) begin
      #1;
      vec++; if (m0_bus.err !== 1'b0) begin miss++; $display("FAIL to_early%0d got %b want 0", c, m0_bus.err); end
      tick();
    end
    #1;
    vec++; if (m0_bus.err !== 1'b1)   begin miss++; $display("FAIL to_err got %b want 1", m0_bus.err); end
    vec++; if (s_bus.cyc !== 1'b0)    begin miss++; $display("FAIL to_cyc got %b want 0", s_bus.cyc); end
    vec++; if (s_bus.stb !== 1'b0)    begin miss++; $display("FAIL to_stb got %b want 0", s_bus.stb); end
    vec++; if (m1_bus.err !== 1'b0)   begin miss++; $display("FAIL to_m1err got %b want 0", m1_bus.err); end
    m0_bus.cyc = 0; m0_bus.stb = 0;
    tick();
    vec++; if (gnt !== 2'b00)         begin miss++; $display("FAIL to_idle got %b want 00", gnt); end
    vec++; if (timeout !== 1'b1)      begin miss++; $display("FAIL to_sticky got %b want 1", timeout); end
    slv_en = 1'b1;
    m1_bus.adr = 32'h81; m1_bus.cyc = 1; m1_bus.stb = 1;
    tick(); #1;
    vec++; if (m1_bus.ack !== 1'b1)   begin miss++; $display("FAIL to_next_ack got %b want 1", m1_bus.ack); end
    tick();
    m1_bus.cyc = 0; m1_bus.stb = 0;
    #1;
    vec++; if (timeout !== 1'b0)      begin miss++; $display("FAIL to_clear got %b want 0", timeout); end
    tick();
  endtask
`endif

  initial begin
    for (int a = 0; a < 256; a++) mem[a] = 8'h00;
    test_reset();
    test_single_write();
    test_round_robin();
    test_burst();
    test_abandon();
    test_reset_mid();
`ifdef MEMORY_I2C_WB_ARB_TIMEOUT_EN
    test_timeout();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end
endmodule

// File: doc/memory_i2c_wb_arb.md
Name: memory_i2c_wb_arb

Overview:
Two-master Wishbone B3 arbiter that shares the single-port I2C-backed RAM between the I2C slave sequencer (master 0) and a host/CPU Wishbone master (master 1).
It grants on cyc, holds the grant for the whole cycle (bursts included), and uses round-robin priority on contention.
It sits between both masters and the RAM's Wishbone slave port inside the memory_i2c subsystem.
An optional watchdog terminates hung slave accesses with an error.

Parameters:
AW, 32, address width of all Wishbone ports
DW, 8, data width of all Wishbone ports
SW, 4, select width (kept at 4 to match the RAM sel port)
TIMEOUT, 255, max cycles waiting for s_ack_i/s_err_i before the watchdog fires (only used with the optional feature)

Ports:
clk_i  in  1  system clock, all logic on rising edge
rst_i  in  1  asynchronous reset, active-low
m0_adr_i / m1_adr_i  in  AW  master address
m0_dat_i / m1_dat_i  in  DW  master write data
m0_sel_i / m1_sel_i  in  SW  byte selects
m0_we_i / m1_we_i  in  1  write enable
m0_cyc_i / m1_cyc_i  in  1  bus cycle request
m0_stb_i / m1_stb_i  in  1  strobe
m0_cti_i / m1_cti_i  in  3  cycle type identifier
m0_dat_o / m1_dat_o  out  DW  read data (common s_dat_i fan-out)
m0_ack_o / m1_ack_o  out  1  ack, granted master only
m0_err_o / m1_err_o  out  1  error, granted master only
s_adr_o, s_dat_o, s_sel_o, s_we_o, s_cyc_o, s_stb_o, s_cti_o  out  AW/DW/SW/1/1/1/3  muxed slave request
s_dat_i  in  DW  slave read data
s_ack_i  in  1  slave ack
s_err_i  in  1  slave error
gnt_o  out  2  one-hot current grant (bit0 = m0, bit1 = m1), 2'b00 when idle

Behaviour:
- FSM states IDLE, GNT0, GNT1, registered. Reset → IDLE, last_gnt = 1 (so m0 wins the first tie).
- IDLE:
  - m0_cyc_i only → GNT0; m1_cyc_i only → GNT1.
  - Both requesting → grant the master that is not last_gnt.
  - One cycle arbitration latency: s_cyc_o asserts the cycle after the request is sampled.
- GNTx:
  - s_* request outputs combinationally follow master x.
  - s_ack_i/s_err_i route only to mx_ack_o/mx_err_o; the other master's ack/err are held 0.
  - last_gnt <= x on entry.
  - Leave to IDLE when mx_cyc_i = 0; s_cyc_o drops in that same cycle (combinational).
  - No preemption: the grant is held for the entire cyc, including multi-beat cti bursts and an stb-low gap.
- Fairness: back-to-back contention alternates m0,m1,m0,... with one IDLE cycle between grants.
- IDLE outputs: s_cyc_o = s_stb_o = s_we_o = 0, s_adr_o/s_dat_o/s_sel_o = 0, s_cti_o = 3'b000, gnt_o = 00, all mx_ack_o/mx_err_o = 0.
- mx_dat_o = s_dat_i always; it is valid only alongside mx_ack_o.
- Reset asserted mid-cycle: immediate return to IDLE, all s_* outputs 0 asynchronously, no ack delivered.
- Master dropping cyc before ack: the transfer is abandoned; a late s_ack_i is not forwarded to anyone.
- stb without cyc is ignored.

Optional Feature:
- Macro MEMORY_I2C_WB_ARB_TIMEOUT_EN.
- Defined:
  - Counter of width clog2(TIMEOUT+1) clears on grant entry and on every s_ack_i/s_err_i.
  - It increments each cycle with s_stb_o = 1 and no ack/err.
  - On reaching TIMEOUT: mx_err_o pulses 1 cycle, s_cyc_o/s_stb_o forced 0 for that cycle, FSM → IDLE.
  - A sticky timeout_o output (1 bit, reset 0, cleared on next successful ack) is added.
- Undefined: no counter, no timeout_o port; the arbiter waits indefinitely for the slave.

Test Plan:
1. Single m0 write: adr 0x10, dat 0xA5, we=1 → s_cyc_o rises 1 cycle later, gnt_o = 01, m0_ack_o on s_ack_i, m1_ack_o stays 0; readback by m1 returns 0xA5.
2. Simultaneous m0/m1 reads after reset → m0 granted first, m1 granted after m0 drops cyc plus 1 IDLE cycle; repeated contention 4x gives order m0,m1,m0,m1.
3. m1 4-beat incrementing burst (cti 010…111) while m0 requests → m0 blocked until m1 cyc falls; all 4 acks go to m1 only.
4. m0 drops cyc while stalled with s_ack_i held low, then the slave acks → no ack on either master; FSM in IDLE.
5. rst_i low during GNT1 → s_cyc_o = 0 and gnt_o = 00 the same cycle; after release, the first tie is won by m0.
6. (TIMEOUT_EN, TIMEOUT=8) slave never acks → m0_err_o pulses exactly at cycle 8 of stb, timeout_o = 1, next request granted normally.
